panda_mem_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch (IF) stage and the load/store unit (LSU, MEM stage) of the 5-stage RV32I core. Uses a req/gnt/rvalid handshake on all three interfaces, with one outstanding transaction at a time. Data requests have priority over instruction requests; a starvation counter guarantees forward progress for fetch. Requests are locked while waiting for grant, and responses are routed to the issuing requester.

---
 rtl/panda_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_panda_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the LSU.
// One outstanding transaction, data-first priority with a fetch starvation guard.
module panda_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]     instr_rdata_o,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
    typedef enum logic [1:0] {LOCK_NONE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2} lock_t;

    state_t           state_q, state_d;
    lock_t            lock_q, lock_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic slot;
    logic starve_hit;
    logic sel_instr;
    logic win_req;
    logic grant;

    // State, lock and starvation counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lock_q       <= LOCK_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Slot detection, winner selection, request forwarding and next state.
    always_comb begin
        slot         = 1'b0;
        sel_instr    = 1'b0;
        win_req      = 1'b0;
        grant        = 1'b0;
        starve_hit   = (STARVE_LIMIT > 0) && (starve_cnt_q == LIMIT_C);
        state_d      = state_q;
        lock_d       = lock_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = {BE_W{1'b0}};
        mem_addr_o   = {ADDR_WIDTH{1'b0}};
        mem_wdata_o  = {DATA_WIDTH{1'b0}};

        case (state_q)
            IDLE:           slot = 1'b1;
            BUSY_I, BUSY_D: slot = mem_rvalid_i;
            default:        slot = 1'b0;
        endcase

        // A locked requester keeps the port until it is granted.
        case (lock_q)
            LOCK_I:  sel_instr = 1'b1;
            LOCK_D:  sel_instr = 1'b0;
            default: sel_instr = instr_req_i & (~data_req_i | starve_hit);
        endcase

        win_req   = sel_instr ? instr_req_i : data_req_i;
        mem_req_o = slot & win_req & ~rst_i;
        grant     = mem_req_o & mem_gnt_i;

        if (mem_req_o) begin
            if (sel_instr) begin
                mem_we_o    = 1'b0;
                mem_be_o    = {BE_W{1'b1}};
                mem_addr_o  = instr_addr_i;
                mem_wdata_o = {DATA_WIDTH{1'b0}};
            end else begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end else begin
            mem_we_o = 1'b0;
        end

        if (grant) begin
            lock_d = LOCK_NONE;
            if (sel_instr) begin
                state_d      = BUSY_I;
                starve_cnt_d = '0;
            end else begin
                state_d = BUSY_D;
                if (instr_req_i) begin
                    starve_cnt_d = (starve_cnt_q == LIMIT_C) ? starve_cnt_q
                                                             : starve_cnt_q + CNT_W'(1);
                end else begin
                    starve_cnt_d = '0;
                end
            end
        end else begin
            if (mem_req_o) begin
                lock_d = sel_instr ? LOCK_I : LOCK_D;
            end else begin
                lock_d = lock_q;
            end
            if (state_q != IDLE && mem_rvalid_i) begin
                state_d = IDLE;
            end else begin
                state_d = state_q;
            end
        end
    end

    assign instr_gnt_o    = grant & sel_instr;
    assign data_gnt_o     = grant & ~sel_instr;
    assign instr_rvalid_o = ~rst_i & (state_q == BUSY_I) & mem_rvalid_i;
    assign data_rvalid_o  = ~rst_i & (state_q == BUSY_D) & mem_rvalid_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Self-checking bench for panda_mem_arbiter; responses are matched
// against a scoreboard filled when each grant is issued.
module tb_panda_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    panda_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Response monitor: every rvalid must match the oldest outstanding grant.
    always @(negedge clk_i) begin
        if (instr_rvalid_o || data_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid instr=%0b data=%0b rdata=%h expected no response",
                         instr_rvalid_o, data_rvalid_o, mem_rdata_i);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_rvalid_o !== e.is_d || instr_rvalid_o !== !e.is_d ||
                    (e.is_d ? data_rdata_o : instr_rdata_o) !== e.data) begin
                    errors++;
                    $display("FAIL response_route got i=%0b d=%0b rdata=%h expected d=%0b rdata=%h",
                             instr_rvalid_o, data_rvalid_o,
                             e.is_d ? data_rdata_o : instr_rdata_o, e.is_d, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        mem_rdata_i = 32'h55AA_33CC;
        tick(); tick();
        #2;
        checks++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
             mem_we_o, mem_be_o, mem_addr_o} !== 42'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%0b ig=%0b dg=%0b be=%h addr=%h expected all 0",
                     mem_req_o, instr_gnt_o, data_gnt_o, mem_be_o, mem_addr_o);
        end
        checks++;
        if (instr_rdata_o !== 32'h55AA_33CC || data_rdata_o !== 32'h55AA_33CC) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h expected 55aa33cc", instr_rdata_o, data_rdata_o);
        end
        tick();
        rst_i = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    task automatic test_lone_fetch();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #2;
        checks++;
        if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1 ||
            mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF ||
            mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL lone_fetch_req got ig=%0b dg=%0b addr=%h we=%0b be=%h expected 1 0 00000100 0 f",
                     instr_gnt_o, data_gnt_o, mem_addr_o, mem_we_o, mem_be_o);
        end
        exp_q.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF});
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lone_fetch_resp got irv=%0b drv=%0b req=%0b expected 1 0 0",
                     instr_rvalid_o, data_rvalid_o, mem_req_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_priority();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        data_req_i = 1'b1; data_addr_i = 32'h2000; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        #2;
        checks++;
        if (mem_addr_o !== 32'h2000 || data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL priority_data_first got addr=%h dg=%0b ig=%0b expected 00002000 1 0",
                     mem_addr_o, data_gnt_o, instr_gnt_o);
        end
        exp_q.push_back('{is_d: 1'b1, data: 32'h1111_2222});
        tick();
        data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #2;
        checks++;
        if (mem_addr_o !== 32'h100 || instr_gnt_o !== 1'b1 || data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL priority_b2b got addr=%h ig=%0b drv=%0b expected 00000100 1 1",
                     mem_addr_o, instr_gnt_o, data_rvalid_o);
        end
        exp_q.push_back('{is_d: 1'b0, data: 32'h3333_4444});
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h3333_4444;
        tick();
        clear_inputs();
    endtask

    task automatic test_lock();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b0;
        data_addr_i = 32'h2000; data_be_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) data_req_i = 1'b1;
            if (c == 3) mem_gnt_i = 1'b1;
            #2;
            checks++;
            if (mem_addr_o !== 32'h100 || mem_req_o !== 1'b1 || data_gnt_o !== 1'b0 ||
                instr_gnt_o !== (c == 3)) begin
                errors++;
                $display("FAIL lock_hold cycle %0d got addr=%h ig=%0b dg=%0b expected 00000100 %0b 0",
                         c, mem_addr_o, instr_gnt_o, data_gnt_o, c == 3);
            end
            if (c == 3) exp_q.push_back('{is_d: 1'b0, data: 32'hAAAA_0001});
            tick();
        end
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
        #2;
        checks++;
        if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h2000) begin
            errors++;
            $display("FAIL lock_then_data got dg=%0b addr=%h expected 1 00002000", data_gnt_o, mem_addr_o);
        end
        exp_q.push_back('{is_d: 1'b1, data: 32'hBBBB_0002});
        tick();
        data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hBBBB_0002;
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_instr;
        exp_instr = 6'b100100;
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h300;
        data_req_i = 1'b1; data_addr_i = 32'h400; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_rvalid_i = (k > 0);
            mem_rdata_i = 32'hC000_0000 + k;
            #2;
            checks++;
            if (instr_gnt_o !== exp_instr[k] || data_gnt_o !== !exp_instr[k] ||
                mem_addr_o !== (exp_instr[k] ? 32'h300 : 32'h400)) begin
                errors++;
                $display("FAIL starve_order slot %0d got ig=%0b dg=%0b addr=%h expected ig=%0b",
                         k, instr_gnt_o, data_gnt_o, mem_addr_o, exp_instr[k]);
            end
            exp_q.push_back('{is_d: !exp_instr[k], data: 32'hC000_0000 + k + 1});
            tick();
        end
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC000_0006;
        tick();
        clear_inputs();
    endtask

    task automatic test_store();
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
        data_addr_i = 32'h40; data_wdata_i = 32'h1234; mem_gnt_i = 1'b1;
        #2;
        checks++;
        if (mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'h1234 ||
            mem_addr_o !== 32'h40 || data_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL store_fwd got we=%0b be=%h wdata=%h addr=%h dg=%0b expected 1 3 00001234 00000040 1",
                     mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o, data_gnt_o);
        end
        exp_q.push_back('{is_d: 1'b1, data: 32'h0});
        tick();
        clear_inputs();
        mem_rvalid_i = 1'b1;
        #2;
        checks++;
        if (data_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL store_ack got drv=%0b expected 1", data_rvalid_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h80; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        #2;
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_grant got dg=%0b expected 1", data_gnt_o);
        end
        tick();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
        #2;
        checks++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stray got irv=%0b drv=%0b expected 0 0", instr_rvalid_o, data_rvalid_o);
        end
        tick();
        mem_rvalid_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
        #2;
        checks++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h500) begin
            errors++;
            $display("FAIL reset_mid_refetch got ig=%0b addr=%h expected 1 00000500", instr_gnt_o, mem_addr_o);
        end
        exp_q.push_back('{is_d: 1'b0, data: 32'h77});
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_priority();
        test_lock();
        test_starvation();
        test_store();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
